// File: rtl/rf_pkg.sv
// Shared definitions for the multi-port register file and its dump streamer.
package rf_pkg;

    localparam int XLEN_D  = 32;
    localparam int NREGS_D = 32;

    // Address width for a register file of n entries (at least one bit).
    function automatic int aw_f(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    typedef enum logic [1:0] {
        DUMP_IDLE   = 2'd0,
        DUMP_STREAM = 2'd1,
        DUMP_DONE   = 2'd2
    } dump_state_t;

endpackage

// File: rtl/rf_dump_streamer.sv
// Walks register indices 0..NREGS-1 as a valid/ready stream, then pulses done.
// Register contents come in from the parent's read mux (bypass already applied).
module rf_dump_streamer
    import rf_pkg::*;
#(
    parameter int XLEN  = XLEN_D,
    parameter int NREGS = NREGS_D,
    localparam int AW   = aw_f(NREGS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            start,
    input  logic            ready,
    input  logic [XLEN-1:0] rdata,
    output logic            valid,
    output logic [AW-1:0]   idx,
    output logic [XLEN-1:0] data,
    output logic            done
);

    localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

    dump_state_t st;

    // Dump sequencing; DONE always lasts exactly one cycle, even under stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st  <= DUMP_IDLE;
            idx <= '0;
        end else begin
            case (st)
                DUMP_IDLE: begin
                    if (en && start) begin
                        st  <= DUMP_STREAM;
                        idx <= '0;
                    end
                end
                DUMP_STREAM: begin
                    if (en && ready) begin
                        if (idx == LAST) st <= DUMP_DONE;
                        else             idx <= idx + 1'b1;
                    end
                end
                DUMP_DONE: begin
                    st  <= DUMP_IDLE;
                    idx <= '0;
                end
                default: begin
                    st  <= DUMP_IDLE;
                    idx <= '0;
                end
            endcase
        end
    end

    assign valid = (st == DUMP_STREAM);
    assign done  = (st == DUMP_DONE);
    assign data  = rdata;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-read-port integer register file: combinational reads with same-cycle
// write bypass, stall enable, SP preset on reset, debug dump stream and a flat
// snapshot of all registers.
module reg_file_mp
    import rf_pkg::*;
#(
    parameter int              XLEN     = XLEN_D,
    parameter int              NREGS    = NREGS_D,
    parameter int              NRD      = 2,
    parameter int              SP_IDX   = 2,
    parameter logic [XLEN-1:0] SP_RESET = XLEN'(32'h0000_3FFC),
    localparam int             AW       = aw_f(NREGS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [NRD*AW-1:0]     rd_addr,
    output logic [NRD*XLEN-1:0]   rd_data,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [XLEN-1:0]       wr_data,
    input  logic                  dump_start,
    output logic                  dump_valid,
    input  logic                  dump_ready,
    output logic [AW-1:0]         dump_idx,
    output logic [XLEN-1:0]       dump_data,
    output logic                  dump_done,
    output logic [NREGS*XLEN-1:0] regs_flat
);

    localparam logic [AW:0] NREGS_W = (AW+1)'(NREGS);

    logic [NREGS-1:0][XLEN-1:0] regs;
    logic [XLEN-1:0]            dump_rdata;
    logic                       wr_hit;

    // A write is live only when enabled, not to x0 and inside the array.
    assign wr_hit = en && wr_en && (wr_addr != '0) && ({1'b0, wr_addr} < NREGS_W);

    // Packed layout already puts reg i at [i*XLEN +: XLEN].
    assign regs_flat = regs;

    genvar gi;
    for (gi = 0; gi < NREGS; gi++) begin : g_reg
        if (gi == 0) begin : g_zero
            assign regs[gi] = '0;
        end else begin : g_store
            logic [XLEN-1:0] q;
            // Per-register storage with SP preset.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    q <= (gi == SP_IDX) ? SP_RESET : '0;
                else if (wr_hit && (wr_addr == AW'(gi)))
                    q <= wr_data;
            end
            assign regs[gi] = q;
        end
    end

    // NRD core read ports plus one extra port feeding the dump streamer.
    genvar gk;
    for (gk = 0; gk <= NRD; gk++) begin : g_rd
        logic [AW-1:0]   a;
        logic [XLEN-1:0] v;

        // Read mux: out-of-range and x0 give 0; a live write to the same index wins.
        always_comb begin
            v = '0;
            for (int r = 1; r < NREGS; r++)
                if (a == AW'(r)) v = regs[r];
            if (wr_hit && (a == wr_addr)) v = wr_data;
        end

        if (gk < NRD) begin : g_core
            assign a = rd_addr[gk*AW +: AW];
            assign rd_data[gk*XLEN +: XLEN] = v;
        end else begin : g_dump
            assign a = dump_idx;
            assign dump_rdata = v;
        end
    end

    rf_dump_streamer #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_dump (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .start (dump_start),
        .ready (dump_ready),
        .rdata (dump_rdata),
        .valid (dump_valid),
        .idx   (dump_idx),
        .data  (dump_data),
        .done  (dump_done)
    );

endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench for reg_file_mp: stimulus pushes expected outputs computed
// from an array-based model; a negedge monitor pops and compares.
module tb_reg_file_mp;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int AW    = 5;
    localparam int SPI   = 2;
    localparam logic [XLEN-1:0] SPV = 32'h0000_3FFC;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  en;
    logic [NRD*AW-1:0]     rd_addr;
    logic [NRD*XLEN-1:0]   rd_data;
    logic                  wr_en;
    logic [AW-1:0]         wr_addr;
    logic [XLEN-1:0]       wr_data;
    logic                  dump_start;
    logic                  dump_valid;
    logic                  dump_ready;
    logic [AW-1:0]         dump_idx;
    logic [XLEN-1:0]       dump_data;
    logic                  dump_done;
    logic [NREGS*XLEN-1:0] regs_flat;

    reg_file_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .SP_IDX(SPI), .SP_RESET(SPV)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .dump_start(dump_start), .dump_valid(dump_valid), .dump_ready(dump_ready),
        .dump_idx(dump_idx), .dump_data(dump_data), .dump_done(dump_done),
        .regs_flat(regs_flat)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [XLEN-1:0] rd [NRD];
        logic [XLEN-1:0] regs [NREGS];
        logic            dv;
        logic [AW-1:0]   di;
        logic [XLEN-1:0] dd;
        logic            dn;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: register contents plus where the dump walk currently is.
    logic [XLEN-1:0] mdl [NREGS];
    bit              act;    // beats are being offered
    bit              dn;     // done pulse this cycle
    int              ptr;    // index being offered

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic logic [XLEN-1:0] rexp(input logic [AW-1:0] a);
        if (int'(a) >= NREGS || a == 0) return '0;
        if (en && wr_en && wr_addr != 0 && a == wr_addr) return wr_data;
        return mdl[a];
    endfunction

    task automatic model_reset();
        foreach (mdl[i]) mdl[i] = '0;
        mdl[SPI] = SPV;
        act = 0; dn = 0; ptr = 0;
    endtask

    task automatic model_edge();
        bit a0 = act;
        bit d0 = dn;
        if (en && wr_en && wr_addr != 0 && int'(wr_addr) < NREGS) mdl[wr_addr] = wr_data;
        if (a0 && dump_ready && en) begin
            if (ptr == NREGS-1) begin act = 0; dn = 1; end
            else ptr++;
        end
        if (d0) begin dn = 0; ptr = 0; end
        if (!a0 && !d0 && dump_start && en) begin act = 1; ptr = 0; end
    endtask

    task automatic push_exp();
        exp_t e;
        for (int k = 0; k < NRD; k++) e.rd[k] = rexp(rd_addr[k*AW +: AW]);
        for (int i = 0; i < NREGS; i++) e.regs[i] = mdl[i];
        e.dv = act;
        e.di = AW'(ptr);
        e.dd = rexp(AW'(ptr));
        e.dn = dn;
        sbq.push_back(e);
    endtask

    // One cycle: inputs are already driven (just after a posedge).
    task automatic step();
        push_exp();
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
    endtask

    task automatic setrd(input int a0, input int a1);
        rd_addr[0 +: AW]  = AW'(a0);
        rd_addr[AW +: AW] = AW'(a1);
    endtask

    task automatic wr(input bit we, input int a, input logic [XLEN-1:0] d);
        wr_en = we; wr_addr = AW'(a); wr_data = d;
    endtask

    // Monitor: every cycle the DUT presents reads, snapshot and dump status.
    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            for (int k = 0; k < NRD; k++)
                chk($sformatf("rd_data%0d", k), 64'(rd_data[k*XLEN +: XLEN]), 64'(e.rd[k]));
            begin
                int bad = -1;
                for (int i = NREGS-1; i >= 0; i--)
                    if (regs_flat[i*XLEN +: XLEN] !== e.regs[i]) bad = i;
                if (bad < 0) chk("regs_flat", 64'(0), 64'(0) | 64'(bad + 1));
                else chk($sformatf("regs_flat[%0d]", bad), 64'(regs_flat[bad*XLEN +: XLEN]), 64'(e.regs[bad]));
            end
            chk("dump_valid", 64'(dump_valid), 64'(e.dv));
            chk("dump_done", 64'(dump_done), 64'(e.dn));
            if (e.dv) begin
                chk("dump_idx", 64'(dump_idx), 64'(e.di));
                chk("dump_data", 64'(dump_data), 64'(e.dd));
            end else if (!e.dn) begin
                chk("dump_idx_idle", 64'(dump_idx), 64'(0));
            end
        end
    end

    initial begin
        int n;
        rst_n = 0; en = 1; rd_addr = '0; dump_start = 0; dump_ready = 0;
        wr(0, 0, 0);
        model_reset();
        @(posedge clk); #1;

        // Reset contents visible while reset is held, then after release.
        setrd(SPI, 5); step();
        setrd(0, SPI); step();
        rst_n = 1;
        setrd(SPI, 1); step();

        // Write/read, and x0 stays zero.
        wr(1, 5, 32'hDEADBEEF); setrd(5, 3); step();
        wr(0, 0, 0); setrd(5, 5); step();
        wr(1, 0, 32'h1); setrd(0, 5); step();
        wr(0, 0, 0); step();

        // Same-cycle bypass on both ports.
        wr(1, 7, 32'h55); setrd(7, 7); step();
        wr(0, 0, 0); step();

        // Stall: no write and no bypass.
        en = 0; wr(1, 9, 32'h12); setrd(9, 9); step();
        wr(0, 0, 0); step();
        en = 1; wr(1, 9, 32'h12); step();
        wr(0, 0, 0); step();

        // Full dump of xi = i*3 with ready held high.
        for (int i = 1; i < NREGS; i++) begin
            wr(1, i, XLEN'(i*3)); setrd(i, i-1); step();
        end
        wr(0, 0, 0);
        dump_ready = 1; dump_start = 1; step();
        dump_start = 0;
        repeat (NREGS + 3) step();

        // Backpressure, then reset in the middle of the walk.
        dump_start = 1; step();
        dump_start = 0;
        n = 0;
        while (!(act && ptr == 10) && n < 200) begin
            dump_ready = n[0];
            dump_start = n[2];      // restart attempts while streaming are ignored
            step();
            n++;
        end
        dump_start = 0;
        if (n >= 200) chk("dump_reach_idx10_timeout", 64'(n), 64'(0));
        rst_n = 0; model_reset(); step();
        step();
        rst_n = 1;
        repeat (4) step();

        // Randomised traffic.
        for (int c = 0; c < 3000; c++) begin
            en         = ($urandom % 8) != 0;
            dump_start = ($urandom % 40) == 0;
            dump_ready = ($urandom % 3) != 0;
            wr($urandom % 2, $urandom % NREGS, $urandom);
            if ($urandom % 4 == 0 && act) setrd(ptr, wr_addr);
            else setrd($urandom % NREGS, $urandom % NREGS);
            if ($urandom % 600 == 0) begin
                rst_n = 0; model_reset(); step();
                rst_n = 1;
            end
            step();
        end
        en = 1; wr(0, 0, 0); dump_start = 0;

        n = 0;
        while (sbq.size() > 0 && n < 10) begin @(posedge clk); n++; end
        if (sbq.size() > 0) chk("scoreboard_drain", 64'(sbq.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
